// File: rtl/tlc_pkg.sv
// Shared types and default parameters for the traffic light controller
// and its road-loop sensor conditioner.
package tlc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    QUAL_ON,
    PRESENT,
    QUAL_OFF
  } sensor_state_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int RETRY_CYCLES_DEF    = 16;
  localparam int CNT_W_DEF           = 8;

endpackage

// File: rtl/car_sensor_conditioner_sync_chain.sv
// sync_chain: SYNC_STAGES-deep flop chain for an asynchronous level.
// Ports: clock, reset (sync, active-low), d (async in), q (synced out).
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      stg <= '0;
    end else begin
      stg <= {stg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/car_sensor_conditioner.sv
// Road-loop sensor conditioner: sync, debounce, pending/retry, count.
// Ports: clock, reset (sync, active-low), sensor_raw, green -> car
//        (1-cycle pulse), car_pending, car_count (saturating).
module car_sensor_conditioner
  import tlc_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int RETRY_CYCLES    = RETRY_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sensor_raw,
  input  logic             green,
  output logic             car,
  output logic             car_pending,
  output logic [CNT_W-1:0] car_count
);

  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = $clog2(RETRY_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RTY_LAST = RW'(RETRY_CYCLES - 1);

  logic          sensor_s;
  sensor_state_t state;
  logic [DW-1:0] deb_cnt;
  logic [RW-1:0] rty_cnt;
  logic          detect;
  logic          fire;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (sensor_raw),
    .q    (sensor_s)
  );

  always_comb begin
    detect = (state == QUAL_ON) && sensor_s
             && (deb_cnt == DEB_LAST);
    fire   = car_pending && !green
             && (rty_cnt == RTY_LAST);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      rty_cnt     <= '0;
      car         <= 1'b0;
      car_pending <= 1'b0;
      car_count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sensor_s) begin
            state   <= QUAL_ON;
            deb_cnt <= '0;
          end
        end
        QUAL_ON: begin
          if (!sensor_s) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= PRESENT;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        PRESENT: begin
          if (!sensor_s) begin
            state   <= QUAL_OFF;
            deb_cnt <= '0;
          end
        end
        QUAL_OFF: begin
          if (sensor_s) begin
            state   <= PRESENT;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          deb_cnt <= '0;
        end
      endcase

      // A detect landing right after a retry pulse is swallowed to keep
      // car one cycle wide; pending stays set so the retry reissues it.
      car <= (detect || fire) && !car;

      if (detect) begin
        car_pending <= 1'b1;
      end else if (green) begin
        car_pending <= 1'b0;
      end

      if (detect || fire || !car_pending || green) begin
        rty_cnt <= '0;
      end else begin
        rty_cnt <= rty_cnt + 1'b1;
      end

      if (detect && (car_count != '1)) begin
        car_count <= car_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_car_sensor_conditioner.sv
// Directed bench for car_sensor_conditioner (default and 2-bit count).
// Stimulus driven 1ns after posedge; outputs sampled at the same point.
module tb_car_sensor_conditioner;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sensor_raw = 1'b0;
  logic       green = 1'b0;
  logic       car;
  logic       car_pending;
  logic [7:0] car_count;
  logic       car2;
  logic       car_pending2;
  logic [1:0] car_count2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  car_sensor_conditioner dut (
    .clock      (clock),
    .reset      (reset),
    .sensor_raw (sensor_raw),
    .green      (green),
    .car        (car),
    .car_pending(car_pending),
    .car_count  (car_count)
  );

  car_sensor_conditioner #(
    .CNT_W(2)
  ) dut_w2 (
    .clock      (clock),
    .reset      (reset),
    .sensor_raw (sensor_raw),
    .green      (green),
    .car        (car2),
    .car_pending(car_pending2),
    .car_count  (car_count2)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    sensor_raw = 1'b0;
    green = 1'b0;
    repeat (3) step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      sensor_raw = k[0];
      step();
      n_cmp++;
      if ({car, car_pending, car_count} !== 10'd0) begin
        n_err++;
        $display("FAIL reset_hold k=%0d got car=%b pend=%b cnt=%0d want 0",
                 k, car, car_pending, car_count);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    sensor_raw = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_cmp++;
      if ({car, car_pending, car_count} !== 10'd0) begin
        n_err++;
        $display("FAIL reset_release k=%0d got car=%b pend=%b cnt=%0d want 0",
                 k, car, car_pending, car_count);
      end
    end
  endtask

  task automatic test_clean_arrival();
    apply_reset();
    sensor_raw = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      step();
      if (k == 20) sensor_raw = 1'b0;
      n_cmp++;
      if (car !== (k == 7 || k == 23 || k == 39)) begin
        n_err++;
        $display("FAIL clean_car k=%0d got %b want %b",
                 k, car, (k == 7 || k == 23 || k == 39));
      end
      n_cmp++;
      if (car_pending !== (k >= 7)) begin
        n_err++;
        $display("FAIL clean_pending k=%0d got %b want %b",
                 k, car_pending, (k >= 7));
      end
    end
    n_cmp++;
    if (car_count !== 8'd1) begin
      n_err++;
      $display("FAIL clean_count got %0d want 1", car_count);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    pat = 6'b101101;
    apply_reset();
    for (int k = 1; k <= 40; k++) begin
      if (k <= 6) sensor_raw = pat[6-k];
      else if (k >= 20 && k <= 22) sensor_raw = 1'b0;
      else if (k >= 28 && k <= 30) sensor_raw = 1'b0;
      else sensor_raw = 1'b1;
      green = (k == 15);
      step();
      n_cmp++;
      if (car !== (k == 12)) begin
        n_err++;
        $display("FAIL bounce_car k=%0d got %b want %b",
                 k, car, (k == 12));
      end
    end
    green = 1'b0;
    n_cmp++;
    if (car_count !== 8'd1) begin
      n_err++;
      $display("FAIL bounce_count got %0d want 1", car_count);
    end
    n_cmp++;
    if (car_pending !== 1'b0) begin
      n_err++;
      $display("FAIL bounce_pending got %b want 0", car_pending);
    end
  endtask

  task automatic test_service_ack();
    apply_reset();
    sensor_raw = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      green = (k == 10);
      step();
      n_cmp++;
      if (car !== (k == 7)) begin
        n_err++;
        $display("FAIL ack_car k=%0d got %b want %b", k, car, (k == 7));
      end
      n_cmp++;
      if (car_pending !== (k >= 7 && k < 10)) begin
        n_err++;
        $display("FAIL ack_pending k=%0d got %b want %b",
                 k, car_pending, (k >= 7 && k < 10));
      end
    end
    green = 1'b0;
    apply_reset();
    sensor_raw = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      green = (k == 7);
      step();
      n_cmp++;
      if (car_pending !== (k >= 7)) begin
        n_err++;
        $display("FAIL ack_coincide k=%0d got %b want %b",
                 k, car_pending, (k >= 7));
      end
    end
    green = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp2;
    apply_reset();
    for (int v = 1; v <= 5; v++) begin
      sensor_raw = 1'b1;
      repeat (10) step();
      sensor_raw = 1'b0;
      green = 1'b1;
      step();
      green = 1'b0;
      repeat (10) step();
      exp2 = (v >= 3) ? 2'd3 : 2'(v);
      n_cmp++;
      if (car_count2 !== exp2) begin
        n_err++;
        $display("FAIL sat_count2 v=%0d got %0d want %0d",
                 v, car_count2, exp2);
      end
      n_cmp++;
      if (car_count !== 8'(v)) begin
        n_err++;
        $display("FAIL sat_count8 v=%0d got %0d want %0d",
                 v, car_count, v);
      end
    end
  endtask

  task automatic test_reset_midqual();
    apply_reset();
    sensor_raw = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      reset = (k != 4);
      step();
      n_cmp++;
      if (car !== (k == 11)) begin
        n_err++;
        $display("FAIL midqual_car k=%0d got %b want %b",
                 k, car, (k == 11));
      end
      n_cmp++;
      if (car_pending !== (k >= 11)) begin
        n_err++;
        $display("FAIL midqual_pending k=%0d got %b want %b",
                 k, car_pending, (k >= 11));
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_arrival();
    test_bounce();
    test_service_ack();
    test_saturation();
    test_reset_midqual();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/car_sensor_conditioner.md
Name: car_sensor_conditioner

Overview:
- Upstream stage of traffic_light_controller: turns the raw, asynchronous, bouncy road-loop sensor into the clean `car` request the controller consumes.
- Synchronises, debounces and edge-qualifies the sensor.
- Holds a pending request until the controller shows green, and re-issues the `car` pulse if the request goes unserved.
- Keeps a saturating vehicle count for status.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on sensor_raw (minimum 2).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles needed to accept an edge (minimum 1).
- RETRY_CYCLES, 16, cycles between re-issued car pulses while a request is pending and green=0 (minimum 2).
- CNT_W, 8, width of car_count.

Ports:
- clock  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clock).
- sensor_raw  in  1  asynchronous loop-sensor level; may bounce.
- green  in  1  controller green output; used as the service acknowledge.
- car  out  1  one-cycle request pulse to traffic_light_controller.car.
- car_pending  out  1  a detected vehicle has not yet been served by green.
- car_count  out  CNT_W  saturating count of accepted vehicles.

Behaviour:
- Reset (reset=0 at posedge): all registers clear on that edge.
  - Synchroniser flops = 0, FSM = IDLE, debounce and retry counters = 0.
  - car=0, car_pending=0, car_count=0.
  - Reset asserted mid-operation discards any qualification in progress and any pending request.
- Synchroniser: chain of SYNC_STAGES flops. sensor_s is the last stage. No logic on sensor_raw before the first flop.
- Debounce FSM, states IDLE, QUAL_ON, PRESENT, QUAL_OFF. Counter deb_cnt is cleared on every state entry.
  - IDLE: sensor_s=1 -> QUAL_ON.
  - QUAL_ON: sensor_s=0 -> IDLE. Otherwise, if deb_cnt==DEBOUNCE_CYCLES-1 -> PRESENT and assert detect. Otherwise deb_cnt++.
  - PRESENT: sensor_s=0 -> QUAL_OFF.
  - QUAL_OFF: sensor_s=1 -> PRESENT, with no new detect. Otherwise, if deb_cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise deb_cnt++.
- detect is internal, combinational, one cycle, on the QUAL_ON->PRESENT transition only. One detect per vehicle; bounces never produce extra detects.
- Latency: sensor_raw held at 1 from posedge N gives car=1 registered at posedge N+SYNC_STAGES+DEBOUNCE_CYCLES. With defaults, car is high after the 7th posedge counting the sampling edge as the 1st.
- car_pending:
  - Set on detect.
  - Cleared on any posedge where green=1 and detect=0.
  - detect and green in the same cycle: set wins.
- Retry counter:
  - Cleared on detect, on any car pulse, and whenever car_pending=0 or green=1.
  - Otherwise increments.
  - When it reaches RETRY_CYCLES-1, issue a car pulse and clear.
- car (registered) = detect OR retry-expire, delayed one flop. Always exactly one cycle wide. Never high on two consecutive cycles.
- car_count: +1 on detect. Saturates at 2^CNT_W-1, no wrap.
- No combinational path from any input to any output.

Decomposition:
- Package tlc_pkg:
  - typedef enum logic [1:0] sensor_state_t {IDLE, QUAL_ON, PRESENT, QUAL_OFF}.
  - Default-value localparams shared with the controller bench.
- One sub-module: sync_chain, parameterised by SYNC_STAGES with synchronous active-low reset. Instantiated once for sensor_raw; reused later for an emergency input.
- Debounce FSM, pending/retry logic and counter stay in car_sensor_conditioner.

Test Plan:
- Reset: hold reset=0 for 5 posedges with sensor_raw toggling -> car, car_pending and car_count stay 0. Release at a negedge -> outputs still 0 until a qualified edge.
- Clean arrival: sensor_raw=1 held 20 cycles, green=0 -> car high exactly at posedge 7 for 1 cycle, car_pending=1, car_count=1. Retry pulse at posedge 7+16=23, again at 39.
- Bounce: sensor_raw 1,0,1,1,0,1 (glitches shorter than DEBOUNCE_CYCLES) then stable 1 -> a single car pulse, car_count=1. Dropouts of up to 3 cycles while PRESENT produce no second pulse.
- Service ack: after detect, drive green=1 for 1 cycle at cycle 10 -> car_pending=0 next edge, no retry pulse. Detect coinciding with green=1 -> car_pending stays 1.
- Saturation: CNT_W=2, 5 clean vehicles -> car_count reads 1, 2, 3, 3, 3.
- Reset mid-qualification: sensor_raw=1, assert reset at cycle 4 (QUAL_ON) -> no car pulse. After release with sensor still 1, the full 7-cycle latency restarts.
